// File: rtl/sb_tx_mux_pkg.sv
// Shared types and helpers for the switchboard TX round-robin mux
// and its arbiter.
package sb_tx_mux_pkg;

    // Width of the switchboard destination field.
    localparam int unsigned DEST_W = 32;

    // Upper bound on channel count supported by rr_pick.
    localparam int unsigned MAX_CH = 64;
    localparam int unsigned MAX_CH_W = $clog2(MAX_CH);

    typedef enum logic {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } mux_state_e;

    // Round-robin pick: first set bit of valid after ptr, wrapping modulo nch.
    // Returns 0 when nothing is valid; callers gate with their own any-valid.
    function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] valid,
                                            input int unsigned        ptr,
                                            input int unsigned        nch);
        int unsigned         pick;
        logic                found;
        logic [MAX_CH_W-1:0] idx;
        pick  = 0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            if (k <= nch) begin
                idx = MAX_CH_W'((ptr + k) % nch);
                if (!found && valid[idx]) begin
                    pick  = 32'(idx);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// Round-robin arbiter: combinational pick over a request vector with a
// registered priority pointer that advances only when told to.
module sb_rr_arbiter
    import sb_tx_mux_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [NCH-1:0] i_req,
    input  logic           i_update,
    input  logic [CHW-1:0] i_update_ch,
    output logic [CHW-1:0] o_grant,
    output logic           o_any
);

    logic [CHW-1:0]    r_ptr;
    logic [MAX_CH-1:0] w_req_ext;

    // Zero-extend the request vector to the helper's fixed width.
    always_comb begin
        w_req_ext = '0;
        w_req_ext[NCH-1:0] = i_req;
    end

    assign o_grant = CHW'(rr_pick(w_req_ext, 32'(r_ptr), NCH));
    assign o_any   = |i_req;

    // Pointer resets to the last channel so channel 0 wins first.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= CHW'(NCH - 1);
        end else if (i_update) begin
            r_ptr <= i_update_ch;
        end
    end

endmodule

// File: rtl/sb_tx_rr_mux.sv
// N-channel switchboard TX merge: round-robin arbitration locked per packet,
// single registered output stage.
// Optional feature: define SB_TX_RR_MUX_STATS_EN to add per-channel
// accepted-beat counters on port beat_count.
module sb_tx_rr_mux
    import sb_tx_mux_pkg::*;
#(
    parameter int unsigned NCH                = 4,
    parameter int unsigned DW                 = 416,
    parameter bit          READY_MODE_DEFAULT = 1'b0,
    parameter int unsigned CHW                = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH*DW-1:0]     in_data,
    input  logic [NCH*DEST_W-1:0] in_dest,
    input  logic [NCH-1:0]        in_last,
    input  logic [NCH-1:0]        in_valid,
    output logic [NCH-1:0]        in_ready,
    output logic [DW-1:0]         out_data,
    output logic [DEST_W-1:0]     out_dest,
    output logic                  out_last,
    output logic [CHW-1:0]        out_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  ready_mode
`ifdef SB_TX_RR_MUX_STATS_EN
    ,
    output logic [NCH*32-1:0]     beat_count
`endif
);

    mux_state_e          r_state;
    logic [CHW-1:0]      r_lock_ch;
    logic                r_pace;
    logic                r_out_valid;
    logic [DW-1:0]       r_out_data;
    logic [DEST_W-1:0]   r_out_dest;
    logic                r_out_last;
    logic [CHW-1:0]      r_out_ch;

    logic [CHW-1:0]      w_arb_grant;
    logic                w_arb_any;
    logic [CHW-1:0]      w_grant;
    logic                w_has_req;
    logic                w_mode;
    logic                w_pace_ok;
    logic                w_slot_free;
    logic                w_accept;
    logic [DW-1:0]       w_sel_data;
    logic [DEST_W-1:0]   w_sel_dest;
    logic                w_sel_last;

    sb_rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req       (in_valid),
        .i_update    (w_accept && w_sel_last),
        .i_update_ch (w_grant),
        .o_grant     (w_arb_grant),
        .o_any       (w_arb_any)
    );

    // While locked the owning channel is granted even during bubbles.
    assign w_grant     = (r_state == StLocked) ? r_lock_ch : w_arb_grant;
    assign w_has_req   = (r_state == StLocked) || w_arb_any;
    assign w_mode      = ready_mode ^ READY_MODE_DEFAULT;
    assign w_pace_ok   = !w_mode || !r_pace;
    assign w_slot_free = !r_out_valid || out_ready;

    // One-hot ready on the granted channel only.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = w_slot_free && w_pace_ok && w_has_req && (w_grant == CHW'(i));
        end
    end

    assign w_accept = |(in_valid & in_ready);

    // Mux the granted channel's beat toward the output register.
    always_comb begin
        w_sel_data = '0;
        w_sel_dest = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant == CHW'(i)) begin
                w_sel_data = in_data[i*DW +: DW];
                w_sel_dest = in_dest[i*DEST_W +: DEST_W];
                w_sel_last = in_last[i];
            end
        end
    end

    // Packet lock FSM: lock on a non-last beat, release on the last beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_lock_ch <= '0;
        end else if (w_accept) begin
            unique case (r_state)
                StIdle: begin
                    if (!w_sel_last) begin
                        r_lock_ch <= w_grant;
                        r_state   <= StLocked;
                    end
                end
                StLocked: begin
                    if (w_sel_last) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Pacing toggle runs free in mode 1 and parks at 0 otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pace <= 1'b0;
        end else begin
            r_pace <= w_mode ? ~r_pace : 1'b0;
        end
    end

    // Output stage: load on accept, drop valid when drained, hold when stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_dest  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_slot_free) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data <= w_sel_data;
                r_out_dest <= w_sel_dest;
                r_out_last <= w_sel_last;
                r_out_ch   <= w_grant;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_dest  = r_out_dest;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;

`ifdef SB_TX_RR_MUX_STATS_EN
    logic [NCH*32-1:0] r_beat_count;

    // Per-channel accepted-beat counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_count <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    r_beat_count[i*32 +: 32] <= r_beat_count[i*32 +: 32] + 32'd1;
                end
            end
        end
    end

    assign beat_count = r_beat_count;
`endif

endmodule
